pong_match_controller: RTL and testbench
========================================

Name: pong_match_controller

Overview:
Frame-tick match sequencer for the pong demo. Derives a one-cycle frame tick from vertical_sync, runs the match state machine (idle, serve, play, point pause, game over) and keeps both scores. Gates player move requests into the two paddle instances and drives the ball block's reset, enable and serve direction. Sits between the input pins/debouncers and the paddle/ball objects, in the pixel_clock domain.

Parameters:
SCORE_WIDTH, 4, width of each score counter; SCORE_TO_WIN must be <= 2**SCORE_WIDTH-1.
SCORE_TO_WIN, 7, score that ends the match.
DELAY_WIDTH, 8, width of the frame delay counter.
SERVE_DELAY_FRAMES, 60, frame ticks spent in SERVE before the ball is released (1..2**DELAY_WIDTH-1).
POINT_PAUSE_FRAMES, 90, frame ticks spent in POINT before the next serve (1..2**DELAY_WIDTH-1).

Ports:
pixel_clock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
vertical_sync  in  1  video vsync, synchronous to pixel_clock.
start_button  in  1  level, sampled only on frame ticks.
ball_out_left  in  1  ball crossed left goal (level, sampled on ticks).
ball_out_right  in  1  ball crossed right goal (level, sampled on ticks).
p1_up, p1_down, p2_up, p2_down  in  1 each  raw player move requests.
p1_move_forward, p1_move_backward, p2_move_forward, p2_move_backward  out  1 each  gated paddle commands.
frame_tick  out  1  one-cycle pulse per vsync rising edge.
ball_reset  out  1  one-cycle pulse: recentre ball.
ball_enable  out  1  ball may move.
serve_direction  out  1  0 = serve toward left player, 1 = toward right.
score_left, score_right  out  SCORE_WIDTH  player scores.
winner  out  2  00 none, 01 left, 10 right.
match_state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.

Behaviour:
- Reset (async, any time incl. mid-match): match_state=IDLE, scores=0, winner=00, ball_enable=0, ball_reset=0, frame_tick=0, serve_direction=0, delay counter=0, last_vsync=1 (no tick until a genuine rising edge after reset).
- Tick: internal tick = vertical_sync & ~last_vsync. All state/counter/score updates occur on the clock edge where tick is true; frame_tick is registered and is high the same cycle those updates become visible, for exactly one cycle.
- Paddle gating (combinational): pN_move_forward = pN_down & en, pN_move_backward = pN_up & en, en = (match_state==SERVE || match_state==PLAY). Both requests pass through; paddle treats 11 as no-op.
- IDLE: tick with start_button=1 -> scores=0, winner=00, serve_direction=0, counter=0, ball_reset pulse, -> SERVE.
- SERVE: each tick counter+1; on tick where counter==SERVE_DELAY_FRAMES-1 -> PLAY, ball_enable=1, counter=0. SERVE lasts exactly SERVE_DELAY_FRAMES ticks.
- PLAY, on tick: left&right both 1 -> no score change, serve_direction unchanged, -> POINT. Only left -> score_right+1, serve_direction=0. Only right -> score_left+1, serve_direction=1. New score == SCORE_TO_WIN -> GAME_OVER, winner set (10 right, 01 left); else -> POINT. Any exit: ball_enable=0, counter=0, ball_reset pulse (POINT entry only). Neither asserted -> stay.
- POINT: ball held; on tick where counter==POINT_PAUSE_FRAMES-1 -> SERVE, counter=0; else counter+1.
- GAME_OVER: scores and winner frozen, ball_enable=0; tick with start_button=1 -> IDLE (winner cleared only on next IDLE->SERVE).
- ball_reset: registered, high one cycle, same cycle as the new state (IDLE->SERVE, PLAY->POINT).
- Scores never wrap: match ends at SCORE_TO_WIN. Goal inputs ignored outside PLAY; start ignored outside IDLE/GAME_OVER.

Test Plan:
1. Reset with vertical_sync held 1, release reset -> no frame_tick until vsync falls and rises again; then exactly one 1-cycle frame_tick per rising edge.
2. SERVE_DELAY_FRAMES=3: start=1 on tick -> match_state=1 and ball_reset=1 same cycle; after 3 further ticks match_state=2, ball_enable=1; p1_up gated 0 in IDLE, passes in SERVE/PLAY.
3. PLAY, ball_out_left=1 on tick -> score_right=1, serve_direction=0, match_state=3, ball_reset pulse, ball_enable=0; POINT_PAUSE_FRAMES=2 -> SERVE after 2 ticks.
4. SCORE_TO_WIN=2, right scores twice -> match_state=4, winner=10, score_right=2; further goal inputs ignored; start on tick -> IDLE, then start -> scores 0, winner 00.
5. Both goal inputs 1 on same PLAY tick -> scores unchanged, serve_direction unchanged, POINT entered.
6. Assert reset mid-POINT between ticks -> outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/pong_match_controller.sv
// Pong match sequencer: derives a frame tick from vsync, runs the serve/play/point/game-over
// state machine, keeps both scores and gates paddle moves and ball control.
module pong_match_controller #(
   parameter int SCORE_WIDTH        = 4,
   parameter int SCORE_TO_WIN       = 7,
   parameter int DELAY_WIDTH        = 8,
   parameter int SERVE_DELAY_FRAMES = 60,
   parameter int POINT_PAUSE_FRAMES = 90
) (
   input  logic                   pixel_clock,
   input  logic                   reset,
   input  logic                   vertical_sync,
   input  logic                   start_button,
   input  logic                   ball_out_left,
   input  logic                   ball_out_right,
   input  logic                   p1_up,
   input  logic                   p1_down,
   input  logic                   p2_up,
   input  logic                   p2_down,
   output logic                   p1_move_forward,
   output logic                   p1_move_backward,
   output logic                   p2_move_forward,
   output logic                   p2_move_backward,
   output logic                   frame_tick,
   output logic                   ball_reset,
   output logic                   ball_enable,
   output logic                   serve_direction,
   output logic [SCORE_WIDTH-1:0] score_left,
   output logic [SCORE_WIDTH-1:0] score_right,
   output logic [1:0]             winner,
   output logic [2:0]             match_state
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SERVE     = 3'd1;
   localparam logic [2:0] S_PLAY      = 3'd2;
   localparam logic [2:0] S_POINT     = 3'd3;
   localparam logic [2:0] S_GAME_OVER = 3'd4;

   localparam logic [DELAY_WIDTH-1:0] SERVE_LAST = DELAY_WIDTH'(SERVE_DELAY_FRAMES - 1);
   localparam logic [DELAY_WIDTH-1:0] POINT_LAST = DELAY_WIDTH'(POINT_PAUSE_FRAMES - 1);
   localparam logic [SCORE_WIDTH-1:0] WIN_SCORE  = SCORE_WIDTH'(SCORE_TO_WIN);

   logic [2:0]             r_state;
   logic [DELAY_WIDTH-1:0] r_counter;
   logic [SCORE_WIDTH-1:0] r_score_left;
   logic [SCORE_WIDTH-1:0] r_score_right;
   logic [1:0]             r_winner;
   logic                   r_serve_dir;
   logic                   r_ball_enable;
   logic                   r_ball_reset;
   logic                   r_frame_tick;
   logic                   r_last_vsync;

   logic [2:0]             w_state_next;
   logic [DELAY_WIDTH-1:0] w_counter_next;
   logic [SCORE_WIDTH-1:0] w_score_left_next;
   logic [SCORE_WIDTH-1:0] w_score_right_next;
   logic [SCORE_WIDTH-1:0] w_score_left_inc;
   logic [SCORE_WIDTH-1:0] w_score_right_inc;
   logic [1:0]             w_winner_next;
   logic                   w_serve_dir_next;
   logic                   w_ball_enable_next;
   logic                   w_ball_reset_next;
   logic                   w_tick;
   logic                   w_move_en;

   // last_vsync resets high so a vsync already high at reset release does not tick
   assign w_tick            = vertical_sync & ~r_last_vsync;
   assign w_score_left_inc  = r_score_left + 1'b1;
   assign w_score_right_inc = r_score_right + 1'b1;

   always_ff @(posedge pixel_clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_counter     <= '0;
         r_score_left  <= '0;
         r_score_right <= '0;
         r_winner      <= 2'b00;
         r_serve_dir   <= 1'b0;
         r_ball_enable <= 1'b0;
         r_ball_reset  <= 1'b0;
         r_frame_tick  <= 1'b0;
         r_last_vsync  <= 1'b1;
      end else begin
         r_state       <= w_state_next;
         r_counter     <= w_counter_next;
         r_score_left  <= w_score_left_next;
         r_score_right <= w_score_right_next;
         r_winner      <= w_winner_next;
         r_serve_dir   <= w_serve_dir_next;
         r_ball_enable <= w_ball_enable_next;
         r_ball_reset  <= w_ball_reset_next;
         r_frame_tick  <= w_tick;
         r_last_vsync  <= vertical_sync;
      end
   end

   always_comb begin
      w_state_next       = r_state;
      w_counter_next     = r_counter;
      w_score_left_next  = r_score_left;
      w_score_right_next = r_score_right;
      w_winner_next      = r_winner;
      w_serve_dir_next   = r_serve_dir;
      w_ball_enable_next = r_ball_enable;
      w_ball_reset_next  = 1'b0;
      if (w_tick) begin
         case (r_state)
            S_IDLE: begin
               if (start_button) begin
                  w_score_left_next  = '0;
                  w_score_right_next = '0;
                  w_winner_next      = 2'b00;
                  w_serve_dir_next   = 1'b0;
                  w_counter_next     = '0;
                  w_ball_reset_next  = 1'b1;
                  w_state_next       = S_SERVE;
               end
            end
            S_SERVE: begin
               if (r_counter == SERVE_LAST) begin
                  w_counter_next     = '0;
                  w_ball_enable_next = 1'b1;
                  w_state_next       = S_PLAY;
               end else begin
                  w_counter_next = r_counter + 1'b1;
               end
            end
            S_PLAY: begin
               if (ball_out_left || ball_out_right) begin
                  w_ball_enable_next = 1'b0;
                  w_counter_next     = '0;
                  w_state_next       = S_POINT;
                  w_ball_reset_next  = 1'b1;
                  // a simultaneous double goal is treated as a void rally
                  if (ball_out_left && !ball_out_right) begin
                     w_score_right_next = w_score_right_inc;
                     w_serve_dir_next   = 1'b0;
                     if (w_score_right_inc == WIN_SCORE) begin
                        w_winner_next     = 2'b10;
                        w_state_next      = S_GAME_OVER;
                        w_ball_reset_next = 1'b0;
                     end
                  end else if (ball_out_right && !ball_out_left) begin
                     w_score_left_next = w_score_left_inc;
                     w_serve_dir_next  = 1'b1;
                     if (w_score_left_inc == WIN_SCORE) begin
                        w_winner_next     = 2'b01;
                        w_state_next      = S_GAME_OVER;
                        w_ball_reset_next = 1'b0;
                     end
                  end
               end
            end
            S_POINT: begin
               if (r_counter == POINT_LAST) begin
                  w_counter_next = '0;
                  w_state_next   = S_SERVE;
               end else begin
                  w_counter_next = r_counter + 1'b1;
               end
            end
            S_GAME_OVER: begin
               w_ball_enable_next = 1'b0;
               if (start_button) w_state_next = S_IDLE;
            end
            default: begin
               w_state_next       = S_IDLE;
               w_ball_enable_next = 1'b0;
               w_counter_next     = '0;
            end
         endcase
      end
   end

   always_comb begin
      w_move_en        = (r_state == S_SERVE) || (r_state == S_PLAY);
      p1_move_forward  = p1_down & w_move_en;
      p1_move_backward = p1_up   & w_move_en;
      p2_move_forward  = p2_down & w_move_en;
      p2_move_backward = p2_up   & w_move_en;
      frame_tick       = r_frame_tick;
      ball_reset       = r_ball_reset;
      ball_enable      = r_ball_enable;
      serve_direction  = r_serve_dir;
      score_left       = r_score_left;
      score_right      = r_score_right;
      winner           = r_winner;
      match_state      = r_state;
   end

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller with short serve/pause delays and a 2-point match.
module tb_pong_match_controller;

   logic       pixel_clock = 1'b0;
   logic       reset;
   logic       vertical_sync;
   logic       start_button;
   logic       ball_out_left;
   logic       ball_out_right;
   logic       p1_up, p1_down, p2_up, p2_down;
   logic       p1_move_forward, p1_move_backward, p2_move_forward, p2_move_backward;
   logic       frame_tick, ball_reset, ball_enable, serve_direction;
   logic [3:0] score_left, score_right;
   logic [1:0] winner;
   logic [2:0] match_state;

   int total = 0;
   int fails = 0;

   pong_match_controller #(
      .SCORE_WIDTH(4), .SCORE_TO_WIN(2), .DELAY_WIDTH(8),
      .SERVE_DELAY_FRAMES(3), .POINT_PAUSE_FRAMES(2)
   ) dut (
      .pixel_clock(pixel_clock), .reset(reset), .vertical_sync(vertical_sync),
      .start_button(start_button), .ball_out_left(ball_out_left), .ball_out_right(ball_out_right),
      .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
      .p1_move_forward(p1_move_forward), .p1_move_backward(p1_move_backward),
      .p2_move_forward(p2_move_forward), .p2_move_backward(p2_move_backward),
      .frame_tick(frame_tick), .ball_reset(ball_reset), .ball_enable(ball_enable),
      .serve_direction(serve_direction), .score_left(score_left), .score_right(score_right),
      .winner(winner), .match_state(match_state)
   );

   always #5 pixel_clock = ~pixel_clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // vsync low for one cycle then high; returns 1 time unit after the ticking edge
   task automatic tick();
      @(negedge pixel_clock); vertical_sync = 1'b0;
      @(negedge pixel_clock); vertical_sync = 1'b1;
      @(posedge pixel_clock); #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      reset = 1'b1; vertical_sync = 1'b1; start_button = 1'b0;
      ball_out_left = 1'b0; ball_out_right = 1'b0;
      p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
      repeat (3) @(posedge pixel_clock);
      #1;
      chk("rst_state", match_state, 0);
      chk("rst_score_l", score_left, 0);
      chk("rst_score_r", score_right, 0);
      chk("rst_winner", winner, 0);
      chk("rst_enable", ball_enable, 0);
      chk("rst_ball_reset", ball_reset, 0);
      chk("rst_tick", frame_tick, 0);
      chk("rst_serve_dir", serve_direction, 0);

      // vsync held high across reset release: no tick
      @(negedge pixel_clock); reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge pixel_clock); #1;
         chk("no_tick_after_rst", frame_tick, 0);
      end
      tick();
      chk("first_tick", frame_tick, 1);
      chk("idle_stays", match_state, 0);
      @(posedge pixel_clock); #1;
      chk("tick_one_cycle", frame_tick, 0);

      p1_up = 1'b1; p2_down = 1'b1; #1;
      chk("p1_gated_idle", p1_move_backward, 0);
      chk("p2_gated_idle", p2_move_forward, 0);

      start_button = 1'b1;
      tick();
      chk("serve_state", match_state, 1);
      chk("serve_ball_reset", ball_reset, 1);
      start_button = 1'b0;
      @(posedge pixel_clock); #1;
      chk("ball_reset_pulse", ball_reset, 0);
      chk("p1_pass_serve", p1_move_backward, 1);
      chk("p2_pass_serve", p2_move_forward, 1);
      chk("p1_fwd_idle_req", p1_move_forward, 0);

      ticks(2);
      chk("serve_after2", match_state, 1);
      chk("serve_en_after2", ball_enable, 0);
      tick();
      chk("play_state", match_state, 2);
      chk("play_enable", ball_enable, 1);
      chk("p1_pass_play", p1_move_backward, 1);
      tick();
      chk("play_hold", match_state, 2);

      ball_out_left = 1'b1;
      tick();
      ball_out_left = 1'b0;
      chk("pt1_score_r", score_right, 1);
      chk("pt1_score_l", score_left, 0);
      chk("pt1_dir", serve_direction, 0);
      chk("pt1_state", match_state, 3);
      chk("pt1_ball_reset", ball_reset, 1);
      chk("pt1_enable", ball_enable, 0);
      chk("p1_gated_point", p1_move_backward, 0);
      tick();
      chk("point_after1", match_state, 3);
      tick();
      chk("point_to_serve", match_state, 1);

      ticks(3);
      chk("play2_state", match_state, 2);
      ball_out_right = 1'b1;
      tick();
      ball_out_right = 1'b0;
      chk("pt2_score_l", score_left, 1);
      chk("pt2_dir", serve_direction, 1);
      chk("pt2_state", match_state, 3);

      ticks(5);
      chk("play3_state", match_state, 2);
      ball_out_left = 1'b1; ball_out_right = 1'b1;
      tick();
      ball_out_left = 1'b0; ball_out_right = 1'b0;
      chk("both_state", match_state, 3);
      chk("both_score_l", score_left, 1);
      chk("both_score_r", score_right, 1);
      chk("both_dir", serve_direction, 1);
      chk("both_ball_reset", ball_reset, 1);

      ticks(5);
      chk("play4_state", match_state, 2);
      ball_out_left = 1'b1;
      tick();
      ball_out_left = 1'b0;
      chk("win_state", match_state, 4);
      chk("win_winner", winner, 2'b10);
      chk("win_score_r", score_right, 2);
      chk("win_enable", ball_enable, 0);
      chk("win_no_ball_reset", ball_reset, 0);

      ball_out_right = 1'b1;
      tick();
      ball_out_right = 1'b0;
      chk("go_ignore_goal", score_left, 1);
      chk("go_state_hold", match_state, 4);

      start_button = 1'b1;
      tick();
      chk("go_to_idle", match_state, 0);
      chk("idle_winner_kept", winner, 2'b10);
      chk("idle_score_kept", score_right, 2);
      tick();
      start_button = 1'b0;
      chk("restart_state", match_state, 1);
      chk("restart_score_l", score_left, 0);
      chk("restart_score_r", score_right, 0);
      chk("restart_winner", winner, 0);
      chk("restart_dir", serve_direction, 0);

      ticks(3);
      ball_out_right = 1'b1;
      tick();
      ball_out_right = 1'b0;
      tick();
      chk("pre_rst_state", match_state, 3);
      chk("pre_rst_score_l", score_left, 1);

      // asynchronous reset between clock edges
      @(negedge pixel_clock); #2;
      reset = 1'b1;
      #1;
      chk("async_state", match_state, 0);
      chk("async_score_l", score_left, 0);
      chk("async_dir", serve_direction, 0);
      chk("async_enable", ball_enable, 0);
      chk("async_tick", frame_tick, 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
